// File: rtl/decoder_n_pipe.sv
// Pipelined binary-to-one-hot decoder with a 2-entry output buffer and valid/ready on both sides.
// Out-of-range indices are consumed without output and raise a sticky error flag.
module decoder_n_pipe #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned CNT_WIDTH = 16,
  localparam int unsigned LOG_SIZE = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LOG_SIZE-1:0]  in_encoded,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SIZE-1:0]      out_decoded,
  output logic                 err_range,
  input  logic                 err_clear,
  output logic [CNT_WIDTH-1:0] delivered
);

  localparam logic [LOG_SIZE:0] SIZE_W = (LOG_SIZE + 1)'(SIZE);

  logic [SIZE-1:0]      mem_q [2];
  logic                 head_q, head_d;
  logic [1:0]           occ_q, occ_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic            accept, in_range, push, pop, wr_idx;
  logic [SIZE-1:0] dec;

  assign in_ready  = reset_n & (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign in_range  = ({1'b0, in_encoded} < SIZE_W);
  assign push      = accept & in_range;
  assign pop       = out_valid & out_ready;
  // Tail slot sits one past head only when a single entry is already held.
  assign wr_idx    = head_q ^ (occ_q == 2'd1);

  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      dec[i] = (in_encoded == LOG_SIZE'(i));
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
    // A fresh out-of-range event outranks a clear in the same cycle.
    if (accept && !in_range) begin
      err_d = 1'b1;
    end else if (err_clear) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      occ_q    <= 2'd0;
      head_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      if (push) begin
        mem_q[wr_idx] <= dec;
      end
    end
  end

  assign out_decoded = out_valid ? mem_q[head_q] : '0;
  assign err_range   = err_q;
  assign delivered   = cnt_q;

  if (SIZE < 2 || SIZE > 16) begin : gen_size_check
    $error("decoder_n_pipe: SIZE must be within 2..16");
  end

  assert property (@(posedge clock) $onehot0(out_decoded));

endmodule

// File: tb/tb_decoder_n_pipe.sv
// Bench for decoder_n_pipe: vector table and directed sequences on SIZE=8 and SIZE=6 instances,
// then randomized traffic on SIZE=6 against a queue-based reference model.
module tb_decoder_n_pipe;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        v8, r8, c8, ir8, ov8, er8;
  logic [2:0]  e8;
  logic [7:0]  od8;
  logic [15:0] dl8;

  logic        v6, r6, c6, ir6, ov6, er6;
  logic [2:0]  e6;
  logic [5:0]  od6;
  logic [15:0] dl6;

  decoder_n_pipe #(.SIZE(8), .CNT_WIDTH(16)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(v8), .in_ready(ir8), .in_encoded(e8),
    .out_valid(ov8), .out_ready(r8), .out_decoded(od8), .err_range(er8), .err_clear(c8),
    .delivered(dl8)
  );

  decoder_n_pipe #(.SIZE(6), .CNT_WIDTH(16)) dut6 (
    .clock(clock), .reset_n(reset_n), .in_valid(v6), .in_ready(ir6), .in_encoded(e6),
    .out_valid(ov6), .out_ready(r6), .out_decoded(od6), .err_range(er6), .err_clear(c6),
    .delivered(dl6)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v;
    logic [2:0]  e;
    logic        rdy;
    logic        ov;
    logic [7:0]  od;
    logic        ir;
    logic [15:0] dl;
  } vec_t;

  vec_t tab[18];

  // Reference model state for the randomized phase
  int q[$];
  int m_err;
  int m_cnt;

  initial begin
    // Back-to-back 0..7 with out_ready high
    for (int i = 0; i < 8; i++) begin
      tab[i] = '{1'b1, 3'(i), 1'b1, 1'b1, 8'(1 << i), 1'b1, 16'(i)};
    end
    tab[8]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd8};
    // Backpressure: 3,5 fill the buffer, 6 waits for the first pop
    tab[9]  = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h08, 1'b1, 16'd8};
    tab[10] = '{1'b1, 3'd5, 1'b0, 1'b1, 8'h08, 1'b0, 16'd8};
    tab[11] = '{1'b1, 3'd6, 1'b0, 1'b1, 8'h08, 1'b0, 16'd8};
    tab[12] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h20, 1'b1, 16'd9};
    tab[13] = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h40, 1'b1, 16'd10};
    tab[14] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd11};
    // Simultaneous push and pop at occupancy 1
    tab[15] = '{1'b1, 3'd1, 1'b0, 1'b1, 8'h02, 1'b1, 16'd11};
    tab[16] = '{1'b1, 3'd4, 1'b1, 1'b1, 8'h10, 1'b1, 16'd12};
    tab[17] = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 16'd13};

    {v8, e8, r8, c8} = '0;
    {v6, e6, r6, c6} = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_in_ready_low", {31'd0, ir8}, 32'd0);
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_out_decoded", {24'd0, od8}, 32'd0);
    check("rst_err_range", {31'd0, er8}, 32'd0);
    check("rst_delivered", {16'd0, dl8}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, ir8}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      v8 = tab[i].v; e8 = tab[i].e; r8 = tab[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d_out_valid", i), {31'd0, ov8}, {31'd0, tab[i].ov});
      check($sformatf("vec%0d_out_decoded", i), {24'd0, od8}, {24'd0, tab[i].od});
      check($sformatf("vec%0d_in_ready", i), {31'd0, ir8}, {31'd0, tab[i].ir});
      check($sformatf("vec%0d_delivered", i), {16'd0, dl8}, {16'd0, tab[i].dl});
    end

    // Reset with a full buffer discards both entries
    v8 = 1'b1; e8 = 3'd1; r8 = 1'b0;
    @(negedge clock);
    e8 = 3'd2;
    @(negedge clock);
    check("fill_in_ready", {31'd0, ir8}, 32'd0);
    v8 = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, ir8}, 32'd0);
    @(negedge clock);
    check("midrst_out_valid", {31'd0, ov8}, 32'd0);
    check("midrst_out_decoded", {24'd0, od8}, 32'd0);
    check("midrst_delivered", {16'd0, dl8}, 32'd0);
    check("midrst_err_range", {31'd0, er8}, 32'd0);
    reset_n = 1'b1;
    #1;
    check("midrst_rel_in_ready", {31'd0, ir8}, 32'd1);
    r8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_stale_valid", {31'd0, ov8}, 32'd0);
      check("no_stale_decoded", {24'd0, od8}, 32'd0);
    end
    check("stale_delivered", {16'd0, dl8}, 32'd0);

    // SIZE=6: out-of-range index is dropped and flagged
    v6 = 1'b1; e6 = 3'd7; r6 = 1'b1;
    @(negedge clock);
    check("oor_err_set", {31'd0, er6}, 32'd1);
    check("oor_no_output", {31'd0, ov6}, 32'd0);
    e6 = 3'd2;
    @(negedge clock);
    check("oor_next_decoded", {26'd0, od6}, 32'h04);
    check("oor_err_held", {31'd0, er6}, 32'd1);
    v6 = 1'b0;
    repeat (2) @(negedge clock);
    check("oor_err_sticky", {31'd0, er6}, 32'd1);
    check("oor_delivered", {16'd0, dl6}, 32'd1);
    c6 = 1'b1; v6 = 1'b1; e6 = 3'd6;
    @(negedge clock);
    check("set_beats_clear", {31'd0, er6}, 32'd1);
    check("idx6_no_output", {31'd0, ov6}, 32'd0);
    v6 = 1'b0;
    @(negedge clock);
    check("clear_alone", {31'd0, er6}, 32'd0);
    c6 = 1'b0;

    // Randomized traffic on SIZE=6 against the queue model
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    q.delete();
    m_err = 0;
    m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic acc, pop;
      #1;
      check("rnd_out_valid", {31'd0, ov6}, (q.size() != 0) ? 32'd1 : 32'd0);
      check("rnd_out_decoded", {26'd0, od6}, (q.size() != 0) ? (32'd1 << q[0]) : 32'd0);
      check("rnd_in_ready", {31'd0, ir6}, (q.size() != 2) ? 32'd1 : 32'd0);
      check("rnd_err_range", {31'd0, er6}, 32'(m_err));
      check("rnd_delivered", {16'd0, dl6}, 32'(m_cnt));
      v6 = ($urandom_range(3) != 0);
      e6 = 3'($urandom_range(7));
      r6 = ($urandom_range(2) != 0);
      c6 = ($urandom_range(7) == 0);
      acc = v6 && (q.size() != 2);
      pop = (q.size() != 0) && r6;
      if (pop) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % 65536;
      end
      if (acc && e6 < 3'd6) q.push_back(int'(e6));
      if (acc && e6 >= 3'd6) m_err = 1;
      else if (c6) m_err = 0;
      @(negedge clock);
    end

    check("pow2_err_never", {31'd0, er8}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
